// File: rtl/rs232_pkg.sv
// Shared types and constants for the RS232 three-byte register-access responder.
package rs232_pkg;

   typedef enum logic [2:0] {
      IDLE,
      GET_ADDR,
      GET_DATA,
      EXEC,
      READ_WAIT,
      SEND_ADDR,
      SEND_DATA
   } rs232_state_e;

   // Sub-phase of one reply-byte handshake with the UART transmitter.
   typedef enum logic [1:0] {
      TX_PH_TRIG,
      TX_PH_GAP,
      TX_PH_WAIT
   } rs232_tx_phase_e;

   localparam int         FLOW_RD_BIT           = 0;
   localparam logic [7:0] RS232_DUMMY_BYTE      = 8'hFF;
   localparam int         RS232_TIMEOUT_DEFAULT = 1000000;

   function automatic logic state_drops_byte(rs232_state_e s);
      return (s == EXEC) || (s == READ_WAIT) || (s == SEND_ADDR) || (s == SEND_DATA);
   endfunction

endpackage

// File: rtl/rs232_byte_timeout.sv
// Inter-byte timeout: down-counter reloaded on every byte, one-cycle expiry pulse
// at terminal count, then saturates until the next reload.
module rs232_byte_timeout
   import rs232_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = RS232_TIMEOUT_DEFAULT
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int              CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LOAD  = CNT_W'(TIMEOUT_CYCLES);

   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d  = cnt_q;
      expire = en && !clr && (cnt_q == CNT_W'(1));
      if (clr) begin
         cnt_d = LOAD;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= LOAD;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/rs232_reg_slave.sv
// RS232 register-access responder: parses flow/address/data frames, drives the
// register bus and returns (address, data) replies for reads.
// Optional inter-byte timeout enabled by defining RS232_SLAVE_TIMEOUT_EN.
//
// state     | meaning
// IDLE      | waiting for flow byte
// GET_ADDR  | waiting for address byte
// GET_DATA  | waiting for data / dummy byte
// EXEC      | one-cycle REG_WE or REG_RE strobe
// READ_WAIT | capture REG_RDATA into reply
// SEND_ADDR | transmit address echo
// SEND_DATA | transmit read data
module rs232_reg_slave
   import rs232_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = RS232_TIMEOUT_DEFAULT
) (
   input  logic       CLK_50MHZ,
   input  logic       RST,
   input  logic [7:0] RX_DATA,
   input  logic       RX_DONE,
   output logic [7:0] TX_DATA,
   output logic       TX_TRG,
   input  logic       TX_BUSY,
   output logic [7:0] REG_ADDR,
   output logic [7:0] REG_WDATA,
   output logic       REG_WE,
   output logic       REG_RE,
   input  logic [7:0] REG_RDATA,
   output logic       FRAME_ERR
);

   rs232_state_e    state_q, state_d;
   rs232_tx_phase_e phase_q, phase_d;
   logic            rd_q, rd_d;
   logic [7:0]      addr_q, addr_d;
   logic [7:0]      wdata_q, wdata_d;
   logic [7:0]      reply_q, reply_d;
   logic [7:0]      tx_data_q, tx_data_d;
   logic            timeout_expire;

`ifdef RS232_SLAVE_TIMEOUT_EN
   rs232_byte_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .clk    (CLK_50MHZ),
      .rst_n  (RST),
      .clr    (RX_DONE),
      .en     ((state_q == GET_ADDR) || (state_q == GET_DATA)),
      .expire (timeout_expire)
   );
`else
   assign timeout_expire = 1'b0;
`endif

   assign REG_ADDR  = addr_q;
   assign REG_WDATA = wdata_q;
   assign TX_DATA   = tx_data_q;

   always_comb begin
      state_d   = state_q;
      phase_d   = phase_q;
      rd_d      = rd_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      reply_d   = reply_q;
      tx_data_d = tx_data_q;
      REG_WE    = 1'b0;
      REG_RE    = 1'b0;
      TX_TRG    = 1'b0;
      FRAME_ERR = RX_DONE && state_drops_byte(state_q);

      case (state_q)
         IDLE: begin
            if (RX_DONE) begin
               rd_d    = RX_DATA[FLOW_RD_BIT];
               state_d = GET_ADDR;
            end
         end
         GET_ADDR: begin
            if (RX_DONE) begin
               addr_d  = RX_DATA;
               state_d = GET_DATA;
            end else if (timeout_expire) begin
               FRAME_ERR = 1'b1;
               state_d   = IDLE;
            end
         end
         GET_DATA: begin
            if (RX_DONE) begin
               if (!rd_q) wdata_d = RX_DATA;
               state_d = EXEC;
            end else if (timeout_expire) begin
               FRAME_ERR = 1'b1;
               state_d   = IDLE;
            end
         end
         EXEC: begin
            if (rd_q) begin
               REG_RE  = 1'b1;
               state_d = READ_WAIT;
            end else begin
               REG_WE  = 1'b1;
               state_d = IDLE;
            end
         end
         READ_WAIT: begin
            reply_d   = REG_RDATA;
            tx_data_d = addr_q;
            phase_d   = TX_PH_TRIG;
            state_d   = SEND_ADDR;
         end
         SEND_ADDR, SEND_DATA: begin
            // The transmitter raises busy a cycle late, so the cycle after the
            // trigger is skipped before waiting for busy to clear.
            case (phase_q)
               TX_PH_TRIG: begin
                  if (!TX_BUSY) begin
                     TX_TRG  = 1'b1;
                     phase_d = TX_PH_GAP;
                  end
               end
               TX_PH_GAP: phase_d = TX_PH_WAIT;
               TX_PH_WAIT: begin
                  if (!TX_BUSY) begin
                     phase_d = TX_PH_TRIG;
                     if (state_q == SEND_ADDR) begin
                        tx_data_d = reply_q;
                        state_d   = SEND_DATA;
                     end else begin
                        state_d = IDLE;
                     end
                  end
               end
               default: phase_d = TX_PH_TRIG;
            endcase
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK_50MHZ or negedge RST) begin
      if (!RST) begin
         state_q   <= IDLE;
         phase_q   <= TX_PH_TRIG;
         rd_q      <= 1'b0;
         addr_q    <= 8'h00;
         wdata_q   <= 8'h00;
         reply_q   <= 8'h00;
         tx_data_q <= 8'h00;
      end else begin
         state_q   <= state_d;
         phase_q   <= phase_d;
         rd_q      <= rd_d;
         addr_q    <= addr_d;
         wdata_q   <= wdata_d;
         reply_q   <= reply_d;
         tx_data_q <= tx_data_d;
      end
   end

endmodule

// File: tb/tb_rs232_reg_slave.sv
// Directed self-checking bench for rs232_reg_slave with register-file and
// UART-transmitter models.
module tb_rs232_reg_slave;

   logic       CLK_50MHZ = 1'b0;
   logic       RST = 1'b0;
   logic [7:0] RX_DATA = 8'h00;
   logic       RX_DONE = 1'b0;
   logic [7:0] TX_DATA;
   logic       TX_TRG;
   logic       TX_BUSY = 1'b0;
   logic [7:0] REG_ADDR;
   logic [7:0] REG_WDATA;
   logic       REG_WE;
   logic       REG_RE;
   logic [7:0] REG_RDATA = 8'hEE;
   logic       FRAME_ERR;

   rs232_reg_slave #(.TIMEOUT_CYCLES(100)) dut (
      .CLK_50MHZ (CLK_50MHZ),
      .RST       (RST),
      .RX_DATA   (RX_DATA),
      .RX_DONE   (RX_DONE),
      .TX_DATA   (TX_DATA),
      .TX_TRG    (TX_TRG),
      .TX_BUSY   (TX_BUSY),
      .REG_ADDR  (REG_ADDR),
      .REG_WDATA (REG_WDATA),
      .REG_WE    (REG_WE),
      .REG_RE    (REG_RE),
      .REG_RDATA (REG_RDATA),
      .FRAME_ERR (FRAME_ERR)
   );

   always #10 CLK_50MHZ = ~CLK_50MHZ;

   int total = 0;
   int bad   = 0;

   logic [7:0] mem [256];
   int         we_cnt = 0, re_cnt = 0, ferr_cnt = 0;
   int         viol_cnt = 0, hold_bad = 0, we_long = 0;
   logic       we_prev = 1'b0;
   logic       rd_pending = 1'b0;
   logic [7:0] rd_addr = 8'h00;
   logic [7:0] tx_hold = 8'h00;
   logic [7:0] tx_q [$];
   logic       trg_seen = 1'b0;
   logic       tx_busy_ext = 1'b0;
   int         busy_cnt = 0;

   // Register file, read-data timing and transmitter capture, sampled mid-cycle.
   always @(negedge CLK_50MHZ) begin
      if (REG_WE) begin
         mem[REG_ADDR] = REG_WDATA;
         we_cnt++;
         if (we_prev) we_long++;
      end
      we_prev = REG_WE;
      if (REG_RE) re_cnt++;
      if (FRAME_ERR) ferr_cnt++;
      REG_RDATA  = rd_pending ? mem[rd_addr] : 8'hEE;
      rd_pending = REG_RE;
      rd_addr    = REG_ADDR;
      if (TX_TRG) begin
         if (TX_BUSY) viol_cnt++;
         tx_q.push_back(TX_DATA);
         tx_hold  = TX_DATA;
         trg_seen = 1'b1;
      end else if (busy_cnt > 0 && TX_DATA !== tx_hold) begin
         hold_bad++;
      end
   end

   // Transmitter busy rises the cycle after a trigger and lasts 8 cycles.
   always @(posedge CLK_50MHZ) begin
      #1;
      if (busy_cnt > 0) busy_cnt--;
      if (trg_seen) begin
         busy_cnt = 8;
         trg_seen = 1'b0;
      end
      TX_BUSY = tx_busy_ext || (busy_cnt > 0);
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step(input int n = 1);
      repeat (n) begin
         @(posedge CLK_50MHZ);
         #2;
      end
   endtask

   task automatic send_byte(input logic [7:0] b);
      RX_DATA = b;
      RX_DONE = 1'b1;
      step();
      RX_DONE = 1'b0;
      RX_DATA = 8'h00;
   endtask

   task automatic write_frame(input logic [7:0] a, input logic [7:0] d);
      send_byte(8'h00);
      send_byte(a);
      send_byte(d);
      check_eq("we_pulse", REG_WE, 1);
      check_eq("we_addr", REG_ADDR, a);
      check_eq("we_wdata", REG_WDATA, d);
      step();
      check_eq("we_end", REG_WE, 0);
   endtask

   task automatic wait_tx(input int n);
      int k = 0;
      while (tx_q.size() < n && k < 500) begin
         step();
         k++;
      end
      check_eq("tx_count", tx_q.size(), n);
   endtask

   task automatic wait_idle();
      int k = 0;
      while (TX_BUSY && k < 500) begin
         step();
         k++;
      end
      step(3);
   endtask

   task automatic read_frame(input logic [7:0] a, input logic [7:0] exp);
      int n;
      n = tx_q.size();
      send_byte(8'h01);
      send_byte(a);
      send_byte(8'hFF);
      check_eq("re_pulse", REG_RE, 1);
      wait_tx(n + 2);
      if (tx_q.size() >= n + 2) begin
         check_eq("reply_addr", tx_q[n], a);
         check_eq("reply_data", tx_q[n+1], exp);
      end
      wait_idle();
   endtask

   initial begin
      int f0, w0, r0, n;
      foreach (mem[i]) mem[i] = 8'h00;
      mem[8'h19] = 8'h06;

      step(3);
      check_eq("rst_tx_trg", TX_TRG, 0);
      check_eq("rst_tx_data", TX_DATA, 0);
      check_eq("rst_reg_addr", REG_ADDR, 0);
      check_eq("rst_reg_wdata", REG_WDATA, 0);
      check_eq("rst_reg_we", REG_WE, 0);
      check_eq("rst_reg_re", REG_RE, 0);
      check_eq("rst_frame_err", FRAME_ERR, 0);
      RST = 1'b1;
      step(2);

      // single write
      write_frame(8'h18, 8'h03);
      step(20);
      check_eq("write_no_tx", tx_q.size(), 0);
      check_eq("write_we_count", we_cnt, 1);
      check_eq("write_re_count", re_cnt, 0);

      // single read
      read_frame(8'h19, 8'h06);
      check_eq("read_re_count", re_cnt, 1);

      // back-to-back writes then reads
      write_frame(8'h18, 8'h03);
      write_frame(8'h19, 8'h06);
      write_frame(8'h1A, 8'h0C);
      read_frame(8'h19, 8'h06);
      read_frame(8'h18, 8'h03);
      read_frame(8'h1A, 8'h0C);

      // byte arriving while the reply is stalled
      tx_busy_ext = 1'b1;
      step();
      n = tx_q.size();
      send_byte(8'h01);
      send_byte(8'h18);
      send_byte(8'hFF);
      step(6);
      f0 = ferr_cnt;
      send_byte(8'h77);
      step();
      check_eq("drop_ferr", ferr_cnt - f0, 1);
      check_eq("stall_no_trg", tx_q.size(), n);
      tx_busy_ext = 1'b0;
      wait_tx(n + 2);
      if (tx_q.size() >= n + 2) begin
         check_eq("stall_reply_addr", tx_q[n], 8'h18);
         check_eq("stall_reply_data", tx_q[n+1], 8'h03);
      end
      wait_idle();
      write_frame(8'h1B, 8'h5A);
      read_frame(8'h1B, 8'h5A);

      // idle gap mid-frame
      f0 = ferr_cnt;
      w0 = we_cnt;
      send_byte(8'h00);
      send_byte(8'h18);
      step(150);
`ifdef RS232_SLAVE_TIMEOUT_EN
      check_eq("timeout_ferr", ferr_cnt - f0, 1);
      check_eq("timeout_no_we", we_cnt - w0, 0);
      write_frame(8'h20, 8'h55);
`else
      check_eq("gap_no_ferr", ferr_cnt - f0, 0);
      check_eq("gap_no_we", we_cnt - w0, 0);
      send_byte(8'h44);
      check_eq("gap_we", REG_WE, 1);
      check_eq("gap_addr", REG_ADDR, 8'h18);
      check_eq("gap_wdata", REG_WDATA, 8'h44);
      step();
`endif

      // reset in the middle of a read frame
      f0 = ferr_cnt;
      r0 = re_cnt;
      send_byte(8'h01);
      send_byte(8'h19);
      RST = 1'b0;
      #1;
      check_eq("mid_rst_addr", REG_ADDR, 0);
      check_eq("mid_rst_tx_data", TX_DATA, 0);
      check_eq("mid_rst_wdata", REG_WDATA, 0);
      check_eq("mid_rst_tx_trg", TX_TRG, 0);
      check_eq("mid_rst_we_re", {REG_WE, REG_RE}, 0);
      step(2);
      RST = 1'b1;
      step();
      write_frame(8'h21, 8'h99);
      check_eq("mid_rst_no_ferr", ferr_cnt - f0, 0);
      check_eq("mid_rst_no_re", re_cnt - r0, 0);
      read_frame(8'h21, 8'h99);

      check_eq("trg_while_busy", viol_cnt, 0);
      check_eq("tx_data_hold", hold_bad, 0);
      check_eq("we_one_cycle", we_long, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

endmodule
